// File: rtl/vga_pkg.sv
// Shared widths, colour type and colour constants for the bouncing-sprite pixel stage.
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COORD_W      = 10;

  typedef logic [2:0] rgb_t;

  localparam rgb_t RGB_RED   = 3'b100;
  localparam rgb_t RGB_GREEN = 3'b010;
  localparam rgb_t RGB_BLUE  = 3'b001;

  // One left rotation walks green -> red -> blue -> green.
  function automatic rgb_t rgb_rotl(input rgb_t c);
    return {c[1:0], c[2]};
  endfunction
endpackage

// File: rtl/vga_sprite_motion.sv
// One axis of sprite motion: position, direction and wall-hit detection.
// Position and direction update on the clock after i_upd; o_hit is combinational from current state.
module vga_sprite_motion
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int BOX    = 100,
  parameter int STEP   = 1,
  parameter int INIT   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_upd,
  output logic [COORD_W-1:0] o_pos,
  output logic               o_hit
);
  localparam logic [COORD_W:0]   LIMIT   = (COORD_W+1)'(ACTIVE);
  localparam logic [COORD_W:0]   AHEAD   = (COORD_W+1)'(STEP + BOX);
  localparam logic [COORD_W-1:0] MAX_POS = COORD_W'(ACTIVE - BOX);
  localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] INIT_C  = COORD_W'(INIT);

  logic [COORD_W-1:0] r_pos;
  logic               r_dir_pos;
  logic [COORD_W:0]   w_ahead;
  logic               w_hit_hi;
  logic               w_hit_lo;

  // Far-edge test is done one bit wider so it cannot wrap past the screen.
  assign w_ahead  = {1'b0, r_pos} + AHEAD;
  assign w_hit_hi = (w_ahead > LIMIT);
  assign w_hit_lo = (r_pos < STEP_C);
  assign o_hit    = r_dir_pos ? w_hit_hi : w_hit_lo;
  assign o_pos    = r_pos;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos     <= INIT_C;
      r_dir_pos <= 1'b1;
    end else if (i_upd) begin
      if (r_dir_pos) begin
        if (w_hit_hi) begin
          r_pos     <= MAX_POS;
          r_dir_pos <= 1'b0;
        end else begin
          r_pos <= r_pos + STEP_C;
        end
      end else begin
        if (w_hit_lo) begin
          r_pos     <= '0;
          r_dir_pos <= 1'b1;
        end else begin
          r_pos <= r_pos - STEP_C;
        end
      end
    end
  end
endmodule

// File: rtl/vga_bounce_sprite.sv
// Pixel-colour stage drawing a bouncing box; position steps once per FRAME_DIV frames in vblank.
// RGB, syncs and bounce are all registered: pins lag the counters by exactly one pix_clk.
module vga_bounce_sprite
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int BOX_W     = 100,
  parameter int BOX_H     = 100,
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 1,
  parameter int X_INIT    = 0,
  parameter int Y_INIT    = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] h_count,
  input  logic [COORD_W-1:0] v_count,
  input  logic               display_en,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  input  logic               pause,
  output logic               vga_r,
  output logic               vga_g,
  output logic               vga_b,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               bounce
);
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  logic [DIV_W-1:0]   r_div_cnt;
  rgb_t               r_colour;
  logic               w_frame_tick;
  logic               w_tick_run;
  logic               w_upd;
  logic               w_hit_x;
  logic               w_hit_y;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic [COORD_W:0]   w_x_end;
  logic [COORD_W:0]   w_y_end;
  logic               w_in_box;

  // Line 0 of the first blanking row: seen once per frame, well clear of visible pixels.
  assign w_frame_tick = (h_count == '0) && (v_count == COORD_W'(V_ACTIVE));
  assign w_tick_run   = w_frame_tick && !pause;
  assign w_upd        = w_tick_run && (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_tick_run) begin
      r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
    end
  end

  vga_sprite_motion #(
    .ACTIVE(H_ACTIVE), .BOX(BOX_W), .STEP(STEP), .INIT(X_INIT)
  ) u_x (
    .clk(clk), .reset(reset), .i_upd(w_upd), .o_pos(w_x), .o_hit(w_hit_x)
  );

  vga_sprite_motion #(
    .ACTIVE(V_ACTIVE), .BOX(BOX_H), .STEP(STEP), .INIT(Y_INIT)
  ) u_y (
    .clk(clk), .reset(reset), .i_upd(w_upd), .o_pos(w_y), .o_hit(w_hit_y)
  );

  assign w_x_end  = {1'b0, w_x} + (COORD_W+1)'(BOX_W);
  assign w_y_end  = {1'b0, w_y} + (COORD_W+1)'(BOX_H);
  assign w_in_box = (h_count >= w_x) && ({1'b0, h_count} < w_x_end) &&
                    (v_count >= w_y) && ({1'b0, v_count} < w_y_end);

  // A corner hit flags both axes in the same update but rotates the colour only once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_colour  <= RGB_GREEN;
      bounce    <= 1'b0;
      vga_r     <= 1'b0;
      vga_g     <= 1'b0;
      vga_b     <= 1'b0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else begin
      if (w_upd && (w_hit_x || w_hit_y)) begin
        r_colour <= rgb_rotl(r_colour);
      end
      bounce    <= w_upd && (w_hit_x || w_hit_y);
      {vga_r, vga_g, vga_b} <= (display_en && w_in_box) ? r_colour : 3'b000;
      vga_hsync <= h_sync_in;
      vga_vsync <= v_sync_in;
    end
  end
endmodule

// File: tb/tb_vga_bounce_sprite.sv
// Bench for vga_bounce_sprite: four parameterisations driven in lockstep against a behavioural model.
module tb_vga_bounce_sprite;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] h_count = '0;
  logic [9:0] v_count = '0;
  logic       display_en = 1'b0;
  logic       h_sync_in = 1'b1;
  logic       v_sync_in = 1'b1;
  logic       pause = 1'b0;
  logic [N-1:0] o_r, o_g, o_b, o_hs, o_vs, o_bn;

  always #5 clk = ~clk;

  vga_bounce_sprite u0 (
    .clk(clk), .reset(reset), .h_count(h_count), .v_count(v_count), .display_en(display_en),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .pause(pause),
    .vga_r(o_r[0]), .vga_g(o_g[0]), .vga_b(o_b[0]), .vga_hsync(o_hs[0]), .vga_vsync(o_vs[0]),
    .bounce(o_bn[0]));
  vga_bounce_sprite #(.X_INIT(539)) u1 (
    .clk(clk), .reset(reset), .h_count(h_count), .v_count(v_count), .display_en(display_en),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .pause(pause),
    .vga_r(o_r[1]), .vga_g(o_g[1]), .vga_b(o_b[1]), .vga_hsync(o_hs[1]), .vga_vsync(o_vs[1]),
    .bounce(o_bn[1]));
  vga_bounce_sprite #(.X_INIT(540), .Y_INIT(380)) u2 (
    .clk(clk), .reset(reset), .h_count(h_count), .v_count(v_count), .display_en(display_en),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .pause(pause),
    .vga_r(o_r[2]), .vga_g(o_g[2]), .vga_b(o_b[2]), .vga_hsync(o_hs[2]), .vga_vsync(o_vs[2]),
    .bounce(o_bn[2]));
  vga_bounce_sprite #(.FRAME_DIV(3)) u3 (
    .clk(clk), .reset(reset), .h_count(h_count), .v_count(v_count), .display_en(display_en),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .pause(pause),
    .vga_r(o_r[3]), .vga_g(o_g[3]), .vga_b(o_b[3]), .vga_hsync(o_hs[3]), .vga_vsync(o_vs[3]),
    .bounce(o_bn[3]));

  typedef struct {
    int x; int y; int dx; int dy; int div; int xi; int yi; int fd;
    logic [2:0] col;
  } mdl_t;

  typedef struct {
    int h; int v;
    logic [2:0] rgb; logic hs; logic vs;
  } vec_t;

  mdl_t        m[N];
  logic [23:0] sbq[$];
  logic [5:0]  last[N];
  vec_t        tbl[10];
  int          hl[10] = '{0, 1, 99, 100, 101, 539, 540, 541, 639, 656};
  int          vl[9]  = '{0, 1, 99, 100, 101, 379, 380, 381, 479};
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Reference behaviour for one clock edge; returns {rgb,hsync,vsync,bounce} expected after it.
  task automatic model_step(input int i, output logic [5:0] e);
    logic [2:0] pix;
    logic       hit;
    int         h, v;
    h = int'(h_count);
    v = int'(v_count);
    if (reset) begin
      m[i].x = m[i].xi; m[i].y = m[i].yi; m[i].dx = 1; m[i].dy = 1;
      m[i].div = 0; m[i].col = 3'b010;
      e = 6'b000110;
    end else begin
      hit = 1'b0;
      pix = (display_en && h >= m[i].x && h < m[i].x + 100 && v >= m[i].y && v < m[i].y + 100)
            ? m[i].col : 3'b000;
      if (h == 0 && v == 480 && !pause) begin
        if (m[i].div == m[i].fd - 1) begin
          m[i].div = 0;
          if (m[i].dx > 0) begin
            if (m[i].x + 101 > 640) begin m[i].x = 540; m[i].dx = -1; hit = 1'b1; end
            else m[i].x = m[i].x + 1;
          end else begin
            if (m[i].x < 1) begin m[i].x = 0; m[i].dx = 1; hit = 1'b1; end
            else m[i].x = m[i].x - 1;
          end
          if (m[i].dy > 0) begin
            if (m[i].y + 101 > 480) begin m[i].y = 380; m[i].dy = -1; hit = 1'b1; end
            else m[i].y = m[i].y + 1;
          end else begin
            if (m[i].y < 1) begin m[i].y = 0; m[i].dy = 1; hit = 1'b1; end
            else m[i].y = m[i].y - 1;
          end
          if (hit) m[i].col = {m[i].col[1:0], m[i].col[2]};
        end else begin
          m[i].div = m[i].div + 1;
        end
      end
      e = {pix, h_sync_in, v_sync_in, hit};
    end
  endtask

  // One pixel clock from the 800x525 timing model; inputs are parked on idle values
  // before sampling so a missing output register shows up as a difference.
  task automatic drive(input int h, input int v, input logic rst, input logic pz);
    logic [23:0] e;
    logic [5:0]  ei;
    h_count    = 10'(h);
    v_count    = 10'(v);
    reset      = rst;
    pause      = pz;
    display_en = (h < 640) && (v < 480);
    h_sync_in  = !(h >= 656 && h < 752);
    v_sync_in  = !(v >= 490 && v < 492);
    e = '0;
    for (int i = 0; i < N; i++) begin
      model_step(i, ei);
      e[i*6 +: 6] = ei;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    h_count = 10'd799; v_count = 10'd524; display_en = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1;
    #1;
    e = sbq.pop_front();
    for (int i = 0; i < N; i++) begin
      last[i] = {o_r[i], o_g[i], o_b[i], o_hs[i], o_vs[i], o_bn[i]};
      check($sformatf("sb u%0d h%0d v%0d", i, h, v), 32'(last[i]), 32'(e[i*6 +: 6]));
    end
  endtask

  task automatic scan(input logic pz);
    foreach (vl[j]) foreach (hl[k]) drive(hl[k], vl[j], 1'b0, pz);
    drive(700, 479, 1'b0, pz);
  endtask

  task automatic tick(input logic pz);
    drive(0, 480, 1'b0, pz);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1,   1,   3'b010, 1'b1, 1'b1};
    tbl[1] = '{0,   1,   3'b000, 1'b1, 1'b1};
    tbl[2] = '{1,   0,   3'b000, 1'b1, 1'b1};
    tbl[3] = '{100, 100, 3'b010, 1'b1, 1'b1};
    tbl[4] = '{101, 100, 3'b000, 1'b1, 1'b1};
    tbl[5] = '{100, 101, 3'b000, 1'b1, 1'b1};
    tbl[6] = '{50,  50,  3'b010, 1'b1, 1'b1};
    tbl[7] = '{656, 1,   3'b000, 1'b0, 1'b1};
    tbl[8] = '{1,   490, 3'b000, 1'b1, 1'b0};
    tbl[9] = '{639, 479, 3'b000, 1'b1, 1'b1};
    m[0] = '{0, 0, 1, 1, 0, 0,   0,   1, 3'b010};
    m[1] = '{0, 0, 1, 1, 0, 539, 0,   1, 3'b010};
    m[2] = '{0, 0, 1, 1, 0, 540, 380, 1, 3'b010};
    m[3] = '{0, 0, 1, 1, 0, 0,   0,   3, 3'b010};

    // Reset with syncs low and a frame tick present: outputs idle, no motion.
    drive(656, 490, 1'b1, 1'b0);
    drive(0, 480, 1'b1, 1'b0);
    drive(10, 10, 1'b1, 1'b0);
    check("reset outputs", 32'(last[0]), 32'(6'b000110));
    check("reset tick ignored x", 32'(u0.u_x.r_pos), 0);
    check("reset tick ignored div", 32'(u3.r_div_cnt), 0);

    // Frame 1: first update; u2 starts in the corner.
    scan(1'b0);
    tick(1'b0);
    check("u0 x after tick1", 32'(u0.u_x.r_pos), 1);
    check("u0 y after tick1", 32'(u0.u_y.r_pos), 1);
    check("u1 x after tick1", 32'(u1.u_x.r_pos), 540);
    check("u1 no bounce tick1", 32'(last[1][0]), 0);
    check("u2 corner bounce", 32'(last[2][0]), 1);
    check("u2 corner colour", 32'(u2.r_colour), 32'(3'b100));
    check("u2 x held", 32'(u2.u_x.r_pos), 540);
    check("u2 y held", 32'(u2.u_y.r_pos), 380);
    check("u3 div after tick1", 32'(u3.r_div_cnt), 1);
    drive(1, 480, 1'b0, 1'b0);
    check("u2 bounce one clk", 32'(last[2][0]), 0);

    // Pixel/latency vectors against the box at (1,1), green.
    foreach (tbl[t]) begin
      drive(tbl[t].h, tbl[t].v, 1'b0, 1'b0);
      check($sformatf("vec%0d", t), 32'({o_r[0], o_g[0], o_b[0], o_hs[0], o_vs[0]}),
            32'({tbl[t].rgb, tbl[t].hs, tbl[t].vs}));
    end

    // Frame 2: u1 hits the right wall.
    scan(1'b0);
    tick(1'b0);
    check("u1 wall bounce", 32'(last[1][0]), 1);
    check("u1 x clamped", 32'(u1.u_x.r_pos), 540);
    check("u1 colour red", 32'(u1.r_colour), 32'(3'b100));
    check("u2 x moving left", 32'(u2.u_x.r_pos), 539);
    check("u3 div after tick2", 32'(u3.r_div_cnt), 2);
    check("u3 x before div", 32'(u3.u_x.r_pos), 0);

    scan(1'b0);
    tick(1'b0);
    check("u1 x returns", 32'(u1.u_x.r_pos), 539);
    check("u3 div wraps", 32'(u3.r_div_cnt), 0);
    check("u3 x on 3rd tick", 32'(u3.u_x.r_pos), 1);

    scan(1'b0);
    tick(1'b0);
    check("u3 div after tick4", 32'(u3.r_div_cnt), 1);

    // Two paused frames freeze everything.
    for (int f = 0; f < 2; f++) begin
      scan(1'b1);
      tick(1'b1);
    end
    check("pause u3 div", 32'(u3.r_div_cnt), 1);
    check("pause u3 x", 32'(u3.u_x.r_pos), 1);
    check("pause u0 x", 32'(u0.u_x.r_pos), 4);

    for (int f = 0; f < 2; f++) begin
      scan(1'b0);
      tick(1'b0);
    end
    check("u3 x after resume", 32'(u3.u_x.r_pos), 2);
    check("u0 x after resume", 32'(u0.u_x.r_pos), 6);

    // Reset pulsed mid-frame at line 200.
    drive(300, 150, 1'b0, 1'b0);
    drive(300, 200, 1'b1, 1'b0);
    check("midreset u0 x", 32'(u0.u_x.r_pos), 0);
    check("midreset u0 y", 32'(u0.u_y.r_pos), 0);
    check("midreset u2 colour", 32'(u2.r_colour), 32'(3'b010));
    drive(301, 200, 1'b0, 1'b0);
    scan(1'b0);
    tick(1'b0);
    check("post-reset u0 x", 32'(u0.u_x.r_pos), 1);
    check("post-reset u2 bounce", 32'(last[2][0]), 1);
    drive(2, 480, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
